// File: rtl/slink_apb_tgt_tagged_if.sv
// rtl/slink_apb_tgt_tagged_if.sv - APB and S-Link a2l/l2a signal bundle for slink_apb_tgt_tagged
interface slink_apb_tgt_tagged_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int A2LW = 24 + 8 + ADDR_WIDTH + DATA_WIDTH + 8;
    localparam int L2AW = 24 + 8 + DATA_WIDTH + 8;

    logic [ADDR_WIDTH-1:0]   apb_paddr;
    logic                    apb_pwrite;
    logic                    apb_psel;
    logic                    apb_penable;
    logic [DATA_WIDTH-1:0]   apb_pwdata;
    logic [DATA_WIDTH/8-1:0] apb_pstrb;
    logic [DATA_WIDTH-1:0]   apb_prdata;
    logic                    apb_pready;
    logic                    apb_pslverr;

    logic                    a2l_valid;
    logic                    a2l_ready;
    logic [A2LW-1:0]         a2l_data;
    logic                    l2a_valid;
    logic                    l2a_accept;
    logic [L2AW-1:0]         l2a_data;

    // Target side: the APB target front end
    modport slave (
        input  apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata, apb_pstrb,
        output apb_prdata, apb_pready, apb_pslverr,
        output a2l_valid, a2l_data,
        input  a2l_ready,
        input  l2a_valid, l2a_data,
        output l2a_accept
    );

    // Fabric / link side driving the target
    modport master (
        output apb_paddr, apb_pwrite, apb_psel, apb_penable, apb_pwdata, apb_pstrb,
        input  apb_prdata, apb_pready, apb_pslverr,
        input  a2l_valid, a2l_data,
        output a2l_ready,
        output l2a_valid, l2a_data,
        input  l2a_accept
    );
endinterface

// File: rtl/slink_apb_tgt_tagged.sv
// rtl/slink_apb_tgt_tagged.sv - tagged APB target to S-Link request/response bridge (optional SLINK_APB_TGT_TIMEOUT_EN)
module slink_apb_tgt_tagged #(
    parameter int             ADDR_WIDTH       = 32,
    parameter int             DATA_WIDTH       = 32,
    parameter logic [7:0]     APB_READ_DT      = 8'h24,
    parameter logic [7:0]     APB_READ_RSP_DT  = 8'h25,
    parameter logic [7:0]     APB_WRITE_DT     = 8'h26,
    parameter logic [7:0]     APB_WRITE_RSP_DT = 8'h27,
    parameter int             TIMEOUT_CYCLES   = 1024
) (
    input  logic                         apb_clk,
    input  logic                         apb_reset,
    input  logic                         enable,
    slink_apb_tgt_tagged_if.slave        bus,
    output logic [7:0]                   cur_tag,
    output logic                         invalid_resp_pkt,
    output logic                         timeout
);
    localparam int A2LW = 24 + 8 + ADDR_WIDTH + DATA_WIDTH + 8;
    localparam int SW   = DATA_WIDTH / 8;

    localparam logic [15:0] RD_WC = 16'(1 + ADDR_WIDTH / 8);
    localparam logic [15:0] WR_WC = 16'(2 + ADDR_WIDTH / 8 + DATA_WIDTH / 8);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            state;
    logic [7:0]            tag_q;
    logic                  is_write;
    logic                  a2l_valid_q;
    logic [A2LW-1:0]       a2l_data_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;

    logic [7:0]            tag_next;
    logic [A2LW-1:0]       req_pkt;
    logic [7:0]            rsp_dt;
    logic [7:0]            rsp_tag;
    logic                  rsp_status;
    logic                  rsp_match;
    logic                  rsp_take;
    logic                  tmo_hit;

    assign tag_next = tag_q + 8'd1;

    // Assemble the request packet from the APB setup-phase fields
    always_comb begin
        req_pkt                     = '0;
        req_pkt[7:0]                = bus.apb_pwrite ? APB_WRITE_DT : APB_READ_DT;
        req_pkt[23:8]               = bus.apb_pwrite ? WR_WC : RD_WC;
        req_pkt[31:24]              = tag_next;
        req_pkt[32 +: ADDR_WIDTH]   = bus.apb_paddr;
        if (bus.apb_pwrite) begin
            req_pkt[32 + ADDR_WIDTH +: DATA_WIDTH]          = bus.apb_pwdata;
            req_pkt[32 + ADDR_WIDTH + DATA_WIDTH +: SW]     = bus.apb_pstrb;
        end
    end

    // Response decode: write responses carry status right after the tag
    always_comb begin
        rsp_dt     = bus.l2a_data[7:0];
        rsp_tag    = bus.l2a_data[31:24];
        rsp_status = is_write ? bus.l2a_data[32] : bus.l2a_data[32 + DATA_WIDTH];
        rsp_match  = (rsp_dt == (is_write ? APB_WRITE_RSP_DT : APB_READ_RSP_DT))
                     && (rsp_tag == tag_q);
    end

    // Responses are only consumed while waiting on an enabled target
    assign rsp_take       = (state == ST_WAIT) && enable && bus.l2a_valid;
    assign bus.l2a_accept = rsp_take;

`ifdef SLINK_APB_TGT_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Wait-cycle counter, cleared while the request is still pending
    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            wait_cnt <= 16'd0;
        end else if (state == ST_REQ) begin
            wait_cnt <= 16'd0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == ST_WAIT) && enable
                     && (wait_cnt == 16'(TIMEOUT_CYCLES - 1))
                     && !(rsp_take && rsp_match);
`else
    assign tmo_hit = 1'b0;
`endif

    // Transfer sequencing: capture, send, wait for matching response, complete
    always_ff @(posedge apb_clk) begin
        if (apb_reset) begin
            state            <= ST_IDLE;
            tag_q            <= 8'h00;
            is_write         <= 1'b0;
            a2l_valid_q      <= 1'b0;
            a2l_data_q       <= '0;
            prdata_q         <= '0;
            pready_q         <= 1'b0;
            pslverr_q        <= 1'b0;
            invalid_resp_pkt <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            invalid_resp_pkt <= 1'b0;
            timeout          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && bus.apb_psel && !bus.apb_penable) begin
                        tag_q       <= tag_next;
                        a2l_data_q  <= req_pkt;
                        is_write    <= bus.apb_pwrite;
                        a2l_valid_q <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!enable) begin
                        a2l_valid_q <= 1'b0;
                        prdata_q    <= '0;
                        pslverr_q   <= 1'b1;
                        pready_q    <= 1'b1;
                        state       <= ST_RESP;
                    end else if (bus.a2l_ready) begin
                        a2l_valid_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state     <= ST_RESP;
                    end else if (rsp_take && rsp_match) begin
                        prdata_q  <= is_write ? '0 : bus.l2a_data[32 +: DATA_WIDTH];
                        pslverr_q <= rsp_status;
                        pready_q  <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tmo_hit) begin
                        timeout   <= 1'b1;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        pready_q  <= 1'b1;
                        state     <= ST_RESP;
                    end
                    if (rsp_take && !rsp_match) begin
                        invalid_resp_pkt <= 1'b1;
                    end
                end
                ST_RESP: begin
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    pready_q  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A pending request is withdrawn as soon as the block is disabled
    assign bus.a2l_valid   = a2l_valid_q && enable;
    assign bus.a2l_data    = a2l_data_q;
    assign bus.apb_prdata  = prdata_q;
    assign bus.apb_pready  = pready_q;
    assign bus.apb_pslverr = pslverr_q;
    assign cur_tag         = tag_q;
endmodule

// File: tb/tb_slink_apb_tgt_tagged.sv
// tb/tb_slink_apb_tgt_tagged.sv - directed self-checking bench for slink_apb_tgt_tagged
module tb_slink_apb_tgt_tagged;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int A2LW = 104;
    localparam int L2AW = 72;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] cur_tag;
    logic       invalid;
    logic       tmo;

    int n_checks;
    int n_fail;

    slink_apb_tgt_tagged_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    slink_apb_tgt_tagged #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .apb_clk(clk), .apb_reset(rst), .enable(enable), .bus(bus),
        .cur_tag(cur_tag), .invalid_resp_pkt(invalid), .timeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_idle();
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = 1'b0;
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [31:0] rdata,
                            output logic [7:0] tg, output logic [31:0] prd,
                            output logic rdy, output logic err);
        bus.apb_paddr = addr; bus.apb_pwrite = 1'b0;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        tg = bus.a2l_data[31:24];
        bus.apb_penable = 1'b1;
        tick();
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {8'h00, rdata, tg, 16'h0006, 8'h25};
        tick();
        bus.l2a_valid = 1'b0;
        rdy = bus.apb_pready; prd = bus.apb_prdata; err = bus.apb_pslverr;
        apb_idle();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; apb_idle();
        bus.apb_paddr = '0; bus.apb_pwdata = '0; bus.apb_pstrb = '0;
        bus.a2l_ready = 1'b1; bus.l2a_valid = 1'b1; bus.l2a_data = '1;
        repeat (3) tick();
        n_checks++; if (bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %0h want 0", bus.apb_pready); end
        n_checks++; if (bus.apb_pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %0h want 0", bus.apb_pslverr); end
        n_checks++; if (bus.apb_prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %0h want 0", bus.apb_prdata); end
        n_checks++; if (bus.a2l_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a2l_valid: got %0h want 0", bus.a2l_valid); end
        n_checks++; if (bus.a2l_data !== {A2LW{1'b0}}) begin n_fail++; $display("FAIL reset_a2l_data: got %0h want 0", bus.a2l_data); end
        n_checks++; if (bus.l2a_accept !== 1'b0) begin n_fail++; $display("FAIL reset_l2a_accept: got %0h want 0", bus.l2a_accept); end
        n_checks++; if (cur_tag !== 8'h00) begin n_fail++; $display("FAIL reset_cur_tag: got %0h want 0", cur_tag); end
        n_checks++; if (invalid !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %0b%0b want 00", invalid, tmo); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.l2a_accept !== 1'b0) begin n_fail++; $display("FAIL idle_no_accept: got %0h want 0", bus.l2a_accept); end
        bus.l2a_valid = 1'b0;
        tick();
    endtask

    task automatic test_read();
        logic [A2LW-1:0] exp_pkt;
        exp_pkt = {40'h0, 32'h0000_1000, 8'h01, 16'h0005, 8'h24};
        bus.apb_paddr = 32'h0000_1000; bus.apb_pwrite = 1'b0;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.a2l_ready = 1'b1;
        tick();
        n_checks++; if (bus.a2l_valid !== 1'b1) begin n_fail++; $display("FAIL read_a2l_valid: got %0h want 1", bus.a2l_valid); end
        n_checks++; if (bus.a2l_data !== exp_pkt) begin n_fail++; $display("FAIL read_a2l_data: got %0h want %0h", bus.a2l_data, exp_pkt); end
        n_checks++; if (cur_tag !== 8'h01) begin n_fail++; $display("FAIL read_cur_tag: got %0h want 01", cur_tag); end
        bus.apb_penable = 1'b1;
        tick();
        n_checks++; if (bus.a2l_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_drop: got %0h want 0", bus.a2l_valid); end
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {8'h00, 32'hDEAD_BEEF, 8'h01, 16'h0006, 8'h25};
        #1;
        n_checks++; if (bus.l2a_accept !== 1'b1) begin n_fail++; $display("FAIL read_accept: got %0h want 1", bus.l2a_accept); end
        n_checks++; if (bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL read_early_pready: got %0h want 0", bus.apb_pready); end
        tick();
        bus.l2a_valid = 1'b0;
        n_checks++; if (bus.apb_pready !== 1'b1) begin n_fail++; $display("FAIL read_pready: got %0h want 1", bus.apb_pready); end
        n_checks++; if (bus.apb_prdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_prdata: got %0h want deadbeef", bus.apb_prdata); end
        n_checks++; if (bus.apb_pslverr !== 1'b0) begin n_fail++; $display("FAIL read_pslverr: got %0h want 0", bus.apb_pslverr); end
        apb_idle();
        tick();
        n_checks++; if (bus.apb_pready !== 1'b0 || bus.apb_prdata !== 32'h0) begin n_fail++; $display("FAIL read_pready_one_cycle: got %0h/%0h want 0/0", bus.apb_pready, bus.apb_prdata); end
    endtask

    task automatic test_write_backpressure();
        logic [A2LW-1:0] exp_pkt;
        exp_pkt = {8'h0C, 32'h1234_5678, 32'h0000_0040, 8'h02, 16'h000A, 8'h26};
        bus.a2l_ready = 1'b0;
        bus.apb_paddr = 32'h40; bus.apb_pwdata = 32'h1234_5678; bus.apb_pstrb = 4'hC;
        bus.apb_pwrite = 1'b1; bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.a2l_valid !== 1'b1) begin n_fail++; $display("FAIL write_valid_c%0d: got %0h want 1", i, bus.a2l_valid); end
            n_checks++; if (bus.a2l_data !== exp_pkt) begin n_fail++; $display("FAIL write_data_c%0d: got %0h want %0h", i, bus.a2l_data, exp_pkt); end
            if (i == 3) bus.a2l_ready = 1'b1;
            tick();
        end
        n_checks++; if (bus.a2l_valid !== 1'b0) begin n_fail++; $display("FAIL write_valid_drop: got %0h want 0", bus.a2l_valid); end
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {32'h0, 8'h01, 8'h02, 16'h0002, 8'h27};
        #1;
        n_checks++; if (bus.l2a_accept !== 1'b1) begin n_fail++; $display("FAIL write_accept: got %0h want 1", bus.l2a_accept); end
        tick();
        bus.l2a_valid = 1'b0;
        n_checks++; if (bus.apb_pready !== 1'b1) begin n_fail++; $display("FAIL write_pready: got %0h want 1", bus.apb_pready); end
        n_checks++; if (bus.apb_pslverr !== 1'b1) begin n_fail++; $display("FAIL write_pslverr: got %0h want 1", bus.apb_pslverr); end
        n_checks++; if (bus.apb_prdata !== 32'h0) begin n_fail++; $display("FAIL write_prdata: got %0h want 0", bus.apb_prdata); end
        apb_idle();
        tick();
    endtask

    task automatic test_invalid_resp();
        logic [7:0] tg; logic [31:0] prd; logic rdy; logic err;
        for (int i = 0; i < 2; i++) begin
            run_read(32'h100 + 32'(i), 32'h7700_0000 + 32'(i), tg, prd, rdy, err);
            n_checks++; if (tg !== 8'(3 + i)) begin n_fail++; $display("FAIL inv_pre_tag%0d: got %0h want %0h", i, tg, 3 + i); end
            n_checks++; if (rdy !== 1'b1 || prd !== 32'h7700_0000 + 32'(i)) begin n_fail++; $display("FAIL inv_pre_read%0d: got %0h/%0h", i, rdy, prd); end
        end
        bus.apb_paddr = 32'h2000; bus.apb_pwrite = 1'b0;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        n_checks++; if (cur_tag !== 8'h05) begin n_fail++; $display("FAIL inv_cur_tag: got %0h want 05", cur_tag); end
        bus.apb_penable = 1'b1;
        tick();
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {32'h0, 8'h00, 8'h05, 16'h0002, 8'h27};
        #1;
        n_checks++; if (bus.l2a_accept !== 1'b1) begin n_fail++; $display("FAIL inv_wrdt_accept: got %0h want 1", bus.l2a_accept); end
        tick();
        n_checks++; if (invalid !== 1'b1 || bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL inv_wrdt_pulse: got inv %0h rdy %0h want 1/0", invalid, bus.apb_pready); end
        bus.l2a_data = {8'h00, 32'hBAD0_BAD0, 8'h04, 16'h0006, 8'h25};
        #1;
        n_checks++; if (bus.l2a_accept !== 1'b1) begin n_fail++; $display("FAIL inv_tag_accept: got %0h want 1", bus.l2a_accept); end
        tick();
        n_checks++; if (invalid !== 1'b1 || bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL inv_tag_pulse: got inv %0h rdy %0h want 1/0", invalid, bus.apb_pready); end
        bus.l2a_valid = 1'b0;
        tick();
        n_checks++; if (invalid !== 1'b0 || bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL inv_quiet: got inv %0h rdy %0h want 0/0", invalid, bus.apb_pready); end
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {8'h00, 32'h5555_AAAA, 8'h05, 16'h0006, 8'h25};
        tick();
        bus.l2a_valid = 1'b0;
        n_checks++; if (bus.apb_pready !== 1'b1 || bus.apb_prdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL inv_complete: got %0h/%0h want 1/5555aaaa", bus.apb_pready, bus.apb_prdata); end
        apb_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] tg; logic [31:0] prd; logic rdy; logic err;
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            d = 32'hC0DE_0000 + 32'(i);
            run_read(32'(i * 4), d, tg, prd, rdy, err);
            n_checks++; if (tg !== 8'(i + 1)) begin n_fail++; $display("FAIL b2b_tag%0d: got %0h want %0h", i, tg, 8'(i + 1)); end
            n_checks++; if (rdy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_done%0d: got rdy %0h err %0h want 1/0", i, rdy, err); end
            n_checks++; if (prd !== d) begin n_fail++; $display("FAIL b2b_data%0d: got %0h want %0h", i, prd, d); end
        end
        n_checks++; if (cur_tag !== 8'h00) begin n_fail++; $display("FAIL b2b_wrap: got %0h want 00", cur_tag); end
    endtask

    task automatic test_disable();
        bus.a2l_ready = 1'b0;
        bus.apb_paddr = 32'h3000; bus.apb_pwrite = 1'b0;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        n_checks++; if (bus.a2l_valid !== 1'b1) begin n_fail++; $display("FAIL dis_req_valid: got %0h want 1", bus.a2l_valid); end
        enable = 1'b0;
        #1;
        n_checks++; if (bus.a2l_valid !== 1'b0) begin n_fail++; $display("FAIL dis_req_valid_drop: got %0h want 0", bus.a2l_valid); end
        tick();
        n_checks++; if (bus.apb_pready !== 1'b1 || bus.apb_pslverr !== 1'b1 || bus.apb_prdata !== 32'h0) begin n_fail++; $display("FAIL dis_req_abort: got %0h/%0h/%0h want 1/1/0", bus.apb_pready, bus.apb_pslverr, bus.apb_prdata); end
        enable = 1'b1; bus.a2l_ready = 1'b1; apb_idle();
        tick();
        n_checks++; if (bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL dis_req_pready_clear: got %0h want 0", bus.apb_pready); end
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        n_checks++; if (bus.apb_pready !== 1'b1 || bus.apb_pslverr !== 1'b1 || bus.apb_prdata !== 32'h0) begin n_fail++; $display("FAIL dis_wait_abort: got %0h/%0h/%0h want 1/1/0", bus.apb_pready, bus.apb_pslverr, bus.apb_prdata); end
        enable = 1'b1; apb_idle();
        tick();
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        tick();
        bus.l2a_valid = 1'b1;
        bus.l2a_data  = {8'h00, 32'h1111_2222, 8'h02, 16'h0006, 8'h25};
        #1;
        n_checks++; if (bus.l2a_accept !== 1'b1) begin n_fail++; $display("FAIL dis_stale_accept: got %0h want 1", bus.l2a_accept); end
        tick();
        n_checks++; if (invalid !== 1'b1 || bus.apb_pready !== 1'b0) begin n_fail++; $display("FAIL dis_stale_pulse: got inv %0h rdy %0h want 1/0", invalid, bus.apb_pready); end
        bus.l2a_data = {8'h00, 32'h3333_4444, 8'h03, 16'h0006, 8'h25};
        tick();
        bus.l2a_valid = 1'b0;
        n_checks++; if (bus.apb_pready !== 1'b1 || bus.apb_pslverr !== 1'b0 || bus.apb_prdata !== 32'h3333_4444) begin n_fail++; $display("FAIL dis_next_complete: got %0h/%0h/%0h want 1/0/33334444", bus.apb_pready, bus.apb_pslverr, bus.apb_prdata); end
        apb_idle();
        tick();
    endtask

    task automatic test_timeout();
        int  n;
        logic seen_tmo;
        logic seen_err;
        bus.apb_paddr = 32'h4000; bus.apb_pwrite = 1'b0;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        tick();
        n = 0; seen_tmo = 1'b0; seen_err = 1'b0;
`ifdef SLINK_APB_TGT_TIMEOUT_EN
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus.apb_pready === 1'b1) begin
                n = k; seen_tmo = tmo; seen_err = bus.apb_pslverr;
                break;
            end
        end
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL tmo_latency: got %0d want 16", n); end
        n_checks++; if (seen_tmo !== 1'b1 || seen_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flags: got tmo %0h err %0h want 1/1", seen_tmo, seen_err); end
        apb_idle();
        tick();
`else
        for (int k = 1; k <= 1000; k++) begin
            tick();
            if (bus.apb_pready === 1'b1 || tmo === 1'b1) n = k;
        end
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL notmo_hang: completed at cycle %0d want never", n); end
        enable = 1'b0;
        tick();
        n_checks++; if (bus.apb_pready !== 1'b1 || bus.apb_pslverr !== 1'b1) begin n_fail++; $display("FAIL notmo_recover: got %0h/%0h want 1/1", bus.apb_pready, bus.apb_pslverr); end
        enable = 1'b1; apb_idle();
        tick();
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read();
        test_write_backpressure();
        test_invalid_resp();
        test_back_to_back();
        test_disable();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
